// File: rtl/req_ack_responder_fifo_if.sv
// Handshake bundle for req_ack_responder_fifo.
//   din_valid / din_ready / din : local valid/ready push port into the FIFO
//   req                         : level requests, one bit per consumer
//   ack / dout                  : one-cycle acknowledge with response data
//   count                       : words handed out so far (wraps at 2^32)
//   level                       : current FIFO occupancy
// The slave modport is the responder side; the master modport is the side
// that pushes words and issues requests.
interface req_ack_responder_fifo_if #(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 1
);
    localparam int level_width = $clog2(depth) + 1;

    logic                   din_valid;
    logic                   din_ready;
    logic [data_width-1:0]  din;
    logic [output_size-1:0] req;
    logic                   ack;
    logic [data_width-1:0]  dout;
    logic [31:0]            count;
    logic [level_width-1:0] level;

    modport slave (
        input  din_valid, din, req,
        output din_ready, ack, dout, count, level
    );

    modport master (
        output din_valid, din, req,
        input  din_ready, ack, dout, count, level
    );
endinterface

// File: rtl/req_ack_responder_fifo.sv
// Source side of the req/ack pull protocol. Words pushed on a valid/ready
// port are buffered in a FIFO and handed to downstream consumers, one word
// per acknowledge, once every consumer request line is high.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : req_ack_responder_fifo_if.slave (push port, req, ack, dout,
//         count, level)
module req_ack_responder_fifo #(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    req_ack_responder_fifo_if.slave      bus
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] depth_lvl = (aw + 1)'(depth);

    logic [data_width-1:0] mem [depth];
    logic [aw-1:0]         wr_ptr;
    logic [aw-1:0]         rd_ptr;
    logic [aw:0]           level_q;
    logic                  ack_q;
    logic [data_width-1:0] dout_q;
    logic [31:0]           count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (level_q == depth_lvl);
    assign empty = (level_q == '0);

    // Ready is gated by reset so nothing is accepted while held in reset.
    assign bus.din_ready = rst & ~full;

    assign push = bus.din_valid & bus.din_ready;
    // Blocking on ack_q keeps ack from ever being high two cycles running,
    // which gives consumers a cycle to drop req after seeing ack.
    assign pop  = (&bus.req) & ~ack_q & ~empty;

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ack_q   <= 1'b0;
            dout_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + aw'(1);
                dout_q  <= mem[rd_ptr];
                count_q <= count_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (aw + 1)'(1);
                2'b01:   level_q <= level_q - (aw + 1)'(1);
                default: level_q <= level_q;
            endcase
            ack_q <= pop;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.dout  = dout_q;
    assign bus.count = count_q;
    assign bus.level = level_q;
endmodule

// File: tb/tb_req_ack_responder_fifo.sv
module tb_req_ack_responder_fifo;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    req_ack_responder_fifo_if #(.data_width(32), .depth(DEPTH), .output_size(1)) bus1 ();
    req_ack_responder_fifo_if #(.data_width(32), .depth(DEPTH), .output_size(2)) bus2 ();

    req_ack_responder_fifo #(.data_width(32), .depth(DEPTH), .output_size(1)) u1 (
        .clk(clk), .rst(rst), .bus(bus1));
    req_ack_responder_fifo #(.data_width(32), .depth(DEPTH), .output_size(2)) u2 (
        .clk(clk), .rst(rst), .bus(bus2));

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: a queue of stored words per DUT plus last ack/data/count.
    logic [31:0] mq0[$];
    logic [31:0] mq1[$];
    bit          m_ack[2];
    logic [31:0] m_dout[2];
    logic [31:0] m_cnt[2];

    function automatic int msize(int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    task automatic model_clear();
        mq0.delete();
        mq1.delete();
        for (int k = 0; k < 2; k++) begin
            m_ack[k]  = 1'b0;
            m_dout[k] = '0;
            m_cnt[k]  = '0;
        end
    endtask

    task automatic model_step(int k, bit all_req, bit v, logic [31:0] d);
        bit do_pop;
        bit do_push;
        do_pop  = all_req && !m_ack[k] && msize(k) != 0;
        do_push = v && rst && msize(k) < DEPTH;
        if (do_pop) begin
            m_dout[k] = (k == 0) ? mq0.pop_front() : mq1.pop_front();
            m_cnt[k]  = m_cnt[k] + 32'd1;
        end
        m_ack[k] = do_pop;
        if (do_push) begin
            if (k == 0) mq0.push_back(d);
            else        mq1.push_back(d);
        end
    endtask

    function automatic logic [68:0] observe(int k);
        if (k == 0)
            return {bus1.din_ready, bus1.ack, bus1.dout, bus1.level, bus1.count};
        return {bus2.din_ready, bus2.ack, bus2.dout, bus2.level, bus2.count};
    endfunction

    function automatic logic [68:0] expect_vec(int k);
        logic rdy;
        rdy = rst && (msize(k) < DEPTH);
        return {rdy, m_ack[k], m_dout[k], 3'(msize(k)), m_cnt[k]};
    endfunction

    // Drive one cycle of stimulus, advance the model across the edge and
    // leave time 1 unit after the edge for sampling.
    task automatic tick(bit v, logic [31:0] d, logic r1, logic [1:0] r2);
        bus1.din_valid = v; bus1.din = d; bus1.req = r1;
        bus2.din_valid = v; bus2.din = d; bus2.req = r2;
        @(posedge clk);
        model_step(0, r1, v, d);
        model_step(1, &r2, v, d);
        #1;
    endtask

    task automatic do_reset(int cycles);
        bus1.din_valid = 1'b0; bus2.din_valid = 1'b0;
        rst = 1'b0;
        model_clear();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        bus1.din_valid = 1'b0; bus1.din = '0; bus1.req = 1'b1;
        bus2.din_valid = 1'b0; bus2.din = '0; bus2.req = 2'b11;
        rst = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (observe(k) !== expect_vec(k)) begin
                miscompares++;
                $display("FAIL reset_held dut%0d: got %h expected %h", k, observe(k), expect_vec(k));
            end
        end
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 32'h0, 1'b1, 2'b11);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expect_vec(k)) begin
                    miscompares++;
                    $display("FAIL idle_after_reset dut%0d cyc%0d: got %h expected %h", k, c, observe(k), expect_vec(k));
                end
            end
        end
        vectors++;
        if ({bus1.ack, bus1.count, bus1.din_ready} !== {1'b0, 32'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL idle_const: got ack=%b count=%0d ready=%b expected 0/0/1", bus1.ack, bus1.count, bus1.din_ready);
        end
    endtask

    task automatic test_single_word();
        tick(1'b1, 32'h11, 1'b1, 2'b11);
        vectors++;
        if (bus1.ack !== 1'b0 || bus1.level !== 3'd1) begin
            miscompares++;
            $display("FAIL single_push: got ack=%b level=%0d expected ack=0 level=1", bus1.ack, bus1.level);
        end
        tick(1'b0, 32'h0, 1'b1, 2'b11);
        vectors++;
        if ({bus1.ack, bus1.dout, bus1.count, bus1.level} !== {1'b1, 32'h11, 32'd1, 3'd0}) begin
            miscompares++;
            $display("FAIL single_ack: got ack=%b dout=%h count=%0d level=%0d expected 1/11/1/0",
                     bus1.ack, bus1.dout, bus1.count, bus1.level);
        end
        tick(1'b0, 32'h0, 1'b1, 2'b11);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (observe(k) !== expect_vec(k)) begin
                miscompares++;
                $display("FAIL single_after dut%0d: got %h expected %h", k, observe(k), expect_vec(k));
            end
        end
    endtask

    task automatic test_streaming();
        logic [31:0] got[$];
        int          ack_cyc[$];
        int          idx = 0;
        bit          creq = 1'b1;
        bit          saw_full = 1'b0;
        logic [31:0] cnt0;
        cnt0 = m_cnt[0];
        for (int c = 0; c < 80 && got.size() < 10; c++) begin
            tick(idx < 10, 32'(idx), creq, 2'b00);
            if (idx < 10 && m_ack[0] == 1'b0 && mq0.size() > 0 && mq0[mq0.size()-1] == 32'(idx)) idx++;
            else if (idx < 10 && m_ack[0] == 1'b1 && mq0.size() > 0 && mq0[mq0.size()-1] == 32'(idx)) idx++;
            vectors++;
            if (observe(0) !== expect_vec(0)) begin
                miscompares++;
                $display("FAIL stream dut0 cyc%0d: got %h expected %h", c, observe(0), expect_vec(0));
            end
            if (bus1.level == 3'd4 && bus1.din_ready == 1'b0) saw_full = 1'b1;
            if (bus1.ack) begin
                got.push_back(bus1.dout);
                ack_cyc.push_back(c);
            end
            creq = !bus1.ack;
        end
        vectors++;
        if (got.size() != 10) begin
            miscompares++;
            $display("FAIL stream_count: got %0d words expected 10", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 32'(i)) begin
                miscompares++;
                $display("FAIL stream_order word%0d: got %h expected %h", i, got[i], 32'(i));
            end
        end
        for (int i = 1; i < ack_cyc.size(); i++) begin
            vectors++;
            if (ack_cyc[i] - ack_cyc[i-1] != 2) begin
                miscompares++;
                $display("FAIL stream_rate word%0d: got gap %0d expected 2", i, ack_cyc[i] - ack_cyc[i-1]);
            end
        end
        vectors++;
        if (saw_full !== 1'b1 || bus1.count !== cnt0 + 32'd10) begin
            miscompares++;
            $display("FAIL stream_full_count: got saw_full=%b count=%0d expected 1/%0d", saw_full, bus1.count, cnt0 + 32'd10);
        end
    endtask

    task automatic test_full_boundary();
        logic [31:0] got[$];
        do_reset(1);
        for (int i = 0; i < 6; i++) tick(1'b1, 32'(i), 1'b0, 2'b00);
        vectors++;
        if (bus1.level !== 3'd4 || bus1.din_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_level: got level=%0d ready=%b expected 4/0", bus1.level, bus1.din_ready);
        end
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 32'h0, 1'b1, 2'b00);
            vectors++;
            if (observe(0) !== expect_vec(0)) begin
                miscompares++;
                $display("FAIL full_drain dut0 cyc%0d: got %h expected %h", c, observe(0), expect_vec(0));
            end
            if (bus1.ack) got.push_back(bus1.dout);
        end
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL full_drain_count: got %0d words expected 4", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 32'(i)) begin
                miscompares++;
                $display("FAIL full_drain_word%0d: got %h expected %h", i, got[i], 32'(i));
            end
        end
    endtask

    task automatic test_fanout();
        int acks = 0;
        do_reset(1);
        tick(1'b1, 32'hA5A5_0001, 1'b0, 2'b01);
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 32'h0, 1'b0, 2'b01);
            vectors++;
            if (bus2.ack !== 1'b0 || bus2.level !== 3'd1 || observe(1) !== expect_vec(1)) begin
                miscompares++;
                $display("FAIL fanout_partial cyc%0d: got %h expected %h", c, observe(1), expect_vec(1));
            end
        end
        for (int c = 0; c < 4; c++) begin
            tick(1'b0, 32'h0, 1'b0, 2'b11);
            vectors++;
            if (observe(1) !== expect_vec(1)) begin
                miscompares++;
                $display("FAIL fanout_full cyc%0d: got %h expected %h", c, observe(1), expect_vec(1));
            end
            if (bus2.ack) begin
                acks++;
                vectors++;
                if (bus2.dout !== 32'hA5A5_0001) begin
                    miscompares++;
                    $display("FAIL fanout_data: got %h expected a5a50001", bus2.dout);
                end
            end
        end
        vectors++;
        if (acks != 1 || bus2.count !== 32'd1) begin
            miscompares++;
            $display("FAIL fanout_once: got acks=%0d count=%0d expected 1/1", acks, bus2.count);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1);
        for (int i = 0; i < 4; i++) tick(1'b1, 32'hC0 + 32'(i), 1'b0, 2'b00);
        tick(1'b0, 32'h0, 1'b1, 2'b00);
        vectors++;
        if (bus1.ack !== 1'b1 || bus1.level !== 3'd3) begin
            miscompares++;
            $display("FAIL midrst_setup: got ack=%b level=%0d expected 1/3", bus1.ack, bus1.level);
        end
        #2 rst = 1'b0;
        #1;
        model_clear();
        vectors++;
        if ({bus1.ack, bus1.level, bus1.count} !== {1'b0, 3'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL midrst_async: got ack=%b level=%0d count=%0d expected 0/0/0", bus1.ack, bus1.level, bus1.count);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 32'h0, 1'b1, 2'b11);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expect_vec(k)) begin
                    miscompares++;
                    $display("FAIL midrst_after dut%0d cyc%0d: got %h expected %h", k, c, observe(k), expect_vec(k));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 2) != 0, 2'($urandom));
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expect_vec(k)) begin
                    miscompares++;
                    $display("FAIL random dut%0d cyc%0d: got %h expected %h", k, c, observe(k), expect_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_full_boundary();
        test_fanout();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
